impulse_sweep_ctrl: RTL and testbench

- Stimulus sequencer for OSPFB impulse-response characterisation.
- Emits a registered AXIS sample stream. Each stream is a sequence of M-sample frames with a single impulse at the current phase.
- Holds each phase for a configured number of frames, then steps the phase from phase_lo to phase_hi. It can also insert M-D idle cycles after every D accepted samples, modelling the oversampled input rate.
- Sits in the sim/bring-up source path, upstream of the OSPFB input.

---
 rtl/impulse_sweep_ctrl_pkg.sv | 24 ++
 rtl/impulse_sweep_ctrl_if.sv | 11 +
 rtl/impulse_sweep_ctrl_frame_ctr.sv | 45 ++++
 rtl/impulse_sweep_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_impulse_sweep_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/impulse_sweep_ctrl_pkg.sv
// Shared types and width helpers for the impulse sweep stimulus sequencer.
package impulse_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } sweep_state_t;

  localparam int DEF_FFT_LEN = 64;

  // Counter width that stays legal for ranges of 0 or 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int phase_w(input int fft_len);
    return cnt_w(fft_len);
  endfunction

  localparam int DEF_PHASE_W = phase_w(DEF_FFT_LEN);

endpackage

// File: rtl/impulse_sweep_ctrl_if.sv
// AXI-stream sample channel between the sweep sequencer and its consumer.
interface impulse_sweep_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/impulse_sweep_ctrl_frame_ctr.sv
// Sample-in-frame and decimation counters, both advancing on each accepted beat.
module impulse_sweep_ctrl_frame_ctr
  import impulse_sweep_ctrl_pkg::*;
#(
  parameter int  FFT_LEN = 64,
  parameter int  DEC_FAC = 48,
  localparam int SW      = cnt_w(FFT_LEN),
  localparam int DW      = cnt_w(DEC_FAC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          hs,
  output logic [SW-1:0] samp_ctr,
  output logic [SW-1:0] samp_nxt,
  output logic          samp_wrap,
  output logic          dec_wrap
);

  localparam logic [SW-1:0] SAMP_MAX = SW'(FFT_LEN - 1);
  localparam logic [DW-1:0] DEC_MAX  = DW'(DEC_FAC - 1);

  logic [SW-1:0] samp_r;
  logic [DW-1:0] dec_r;

  assign samp_wrap = (samp_r == SAMP_MAX);
  assign dec_wrap  = (dec_r == DEC_MAX);
  assign samp_nxt  = samp_wrap ? {SW{1'b0}} : (samp_r + SW'(1));
  assign samp_ctr  = samp_r;

  // Both counters clear on a new sweep and step only on a handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_r <= {SW{1'b0}};
      dec_r  <= {DW{1'b0}};
    end else if (clr) begin
      samp_r <= {SW{1'b0}};
      dec_r  <= {DW{1'b0}};
    end else if (hs) begin
      samp_r <= samp_nxt;
      dec_r  <= dec_wrap ? {DW{1'b0}} : (dec_r + DW'(1));
    end
  end

endmodule

// File: rtl/impulse_sweep_ctrl.sv
// Impulse-response sweep source: M-sample frames with one impulse at the current
// phase, optional M-D idle gaps after every D accepted samples.
module impulse_sweep_ctrl
  import impulse_sweep_ctrl_pkg::*;
#(
  parameter int  WIDTH     = 16,
  parameter int  FFT_LEN   = 64,
  parameter int  DEC_FAC   = 48,
  parameter int  PULSE_VAL = 1,
  parameter int  GAP_EN    = 1,
  localparam int PW        = phase_w(FFT_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PW-1:0]         phase_lo,
  input  logic [PW-1:0]         phase_hi,
  input  logic [15:0]           frames,
  output logic                  busy,
  output logic                  done,
  output logic [PW-1:0]         cur_phase,
  impulse_sweep_ctrl_if.master  m_axis
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_GAP  = GAP;
  localparam logic [1:0] ST_DONE = DONE;

  localparam int             GW      = cnt_w(FFT_LEN - DEC_FAC);
  localparam logic [GW-1:0]  GAP_MAX = GW'((FFT_LEN > DEC_FAC) ? (FFT_LEN - DEC_FAC - 1) : 0);
  localparam logic           GAP_ON  = (GAP_EN != 0) && (FFT_LEN > DEC_FAC);
  localparam logic [WIDTH-1:0] PULSE = WIDTH'(PULSE_VAL);

  logic [1:0]       state_r, state_nxt_s;
  logic [GW-1:0]    gap_ctr_r, gap_nxt_s;
  logic [15:0]      frm_ctr_r, frm_nxt_s;
  logic [15:0]      frames_r, frames_nxt_s;
  logic [PW-1:0]    phase_r, phase_nxt_s;
  logic [PW-1:0]    phase_hi_r, hi_nxt_s;
  logic             tvalid_r, tvalid_nxt_s;
  logic [WIDTH-1:0] tdata_r, tdata_nxt_s;
  logic             done_r, done_nxt_s;
  logic             busy_r;
  logic             clr_s, hs_s, sweep_end_s;
  logic [PW-1:0]    samp_ctr_s, samp_nxt_s;
  logic             samp_wrap_s, dec_wrap_s;

  function automatic logic [WIDTH-1:0] sample_at(input logic [PW-1:0] idx,
                                                   input logic [PW-1:0] ph);
    if (idx == ph) begin
      return PULSE;
    end else begin
      return {WIDTH{1'b0}};
    end
  endfunction

  assign hs_s = (state_r == ST_RUN) && tvalid_r && m_axis.tready && !abort;

  impulse_sweep_ctrl_frame_ctr #(
    .FFT_LEN (FFT_LEN),
    .DEC_FAC (DEC_FAC)
  ) u_frame_ctr (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_s),
    .hs        (hs_s),
    .samp_ctr  (samp_ctr_s),
    .samp_nxt  (samp_nxt_s),
    .samp_wrap (samp_wrap_s),
    .dec_wrap  (dec_wrap_s)
  );

  // Next-state, bookkeeping and next output sample; the next beat is precomputed
  // so tready never reaches tdata combinationally.
  always_comb begin
    state_nxt_s  = state_r;
    gap_nxt_s    = gap_ctr_r;
    frm_nxt_s    = frm_ctr_r;
    frames_nxt_s = frames_r;
    phase_nxt_s  = phase_r;
    hi_nxt_s     = phase_hi_r;
    tvalid_nxt_s = tvalid_r;
    tdata_nxt_s  = tdata_r;
    done_nxt_s   = 1'b0;
    clr_s        = 1'b0;
    sweep_end_s  = 1'b0;
    if (abort) begin
      state_nxt_s  = ST_IDLE;
      tvalid_nxt_s = 1'b0;
      tdata_nxt_s  = {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            hi_nxt_s     = phase_hi;
            frames_nxt_s = (frames == 16'd0) ? 16'd1 : frames;
            phase_nxt_s  = phase_lo;
            frm_nxt_s    = 16'd0;
            gap_nxt_s    = {GW{1'b0}};
            clr_s        = 1'b1;
            if (phase_lo > phase_hi) begin
              done_nxt_s = 1'b1;
            end else begin
              state_nxt_s  = ST_RUN;
              tvalid_nxt_s = 1'b1;
              tdata_nxt_s  = sample_at({PW{1'b0}}, phase_lo);
            end
          end else begin
            tvalid_nxt_s = 1'b0;
          end
        end
        ST_RUN: begin
          if (hs_s) begin
            if (samp_wrap_s) begin
              if (frm_ctr_r == (frames_r - 16'd1)) begin
                frm_nxt_s = 16'd0;
                if (phase_r == phase_hi_r) begin
                  sweep_end_s = 1'b1;
                end else begin
                  phase_nxt_s = phase_r + PW'(1);
                end
              end else begin
                frm_nxt_s = frm_ctr_r + 16'd1;
              end
            end else begin
              frm_nxt_s = frm_ctr_r;
            end
            // Finishing the sweep wins over a gap falling on the same beat.
            if (sweep_end_s) begin
              state_nxt_s  = ST_DONE;
              tvalid_nxt_s = 1'b0;
              tdata_nxt_s  = {WIDTH{1'b0}};
              done_nxt_s   = 1'b1;
            end else if (GAP_ON && dec_wrap_s) begin
              state_nxt_s  = ST_GAP;
              tvalid_nxt_s = 1'b0;
              tdata_nxt_s  = {WIDTH{1'b0}};
              gap_nxt_s    = {GW{1'b0}};
            end else begin
              tvalid_nxt_s = 1'b1;
              tdata_nxt_s  = sample_at(samp_nxt_s, phase_nxt_s);
            end
          end else begin
            tvalid_nxt_s = 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_ctr_r == GAP_MAX) begin
            state_nxt_s  = ST_RUN;
            gap_nxt_s    = {GW{1'b0}};
            tvalid_nxt_s = 1'b1;
            tdata_nxt_s  = sample_at(samp_ctr_s, phase_r);
          end else begin
            gap_nxt_s = gap_ctr_r + GW'(1);
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s  = ST_IDLE;
          tvalid_nxt_s = 1'b0;
          tdata_nxt_s  = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      gap_ctr_r  <= {GW{1'b0}};
      frm_ctr_r  <= 16'd0;
      frames_r   <= 16'd0;
      phase_r    <= {PW{1'b0}};
      phase_hi_r <= {PW{1'b0}};
      tvalid_r   <= 1'b0;
      tdata_r    <= {WIDTH{1'b0}};
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      gap_ctr_r  <= gap_nxt_s;
      frm_ctr_r  <= frm_nxt_s;
      frames_r   <= frames_nxt_s;
      phase_r    <= phase_nxt_s;
      phase_hi_r <= hi_nxt_s;
      tvalid_r   <= tvalid_nxt_s;
      tdata_r    <= tdata_nxt_s;
      done_r     <= done_nxt_s;
      busy_r     <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_GAP);
    end
  end

  assign m_axis.tvalid = tvalid_r;
  assign m_axis.tdata  = tdata_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign cur_phase     = phase_r;

endmodule

// File: tb/tb_impulse_sweep_ctrl.sv
// Directed bench: one continuous-rate instance and one gapped instance share control inputs.
module tb_impulse_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [5:0]  phase_lo;
  logic [5:0]  phase_hi;
  logic [15:0] frames;
  logic        rdy_c, rdy_g;
  logic        busy_c, done_c, busy_g, done_g;
  logic [5:0]  cur_phase_c, cur_phase_g;
  int          checks = 0;
  int          failures = 0;
  int          gcyc, gruns, gat, imp, beats;

  impulse_sweep_ctrl_if #(.WIDTH(16)) ifc ();
  impulse_sweep_ctrl_if #(.WIDTH(16)) ifg ();
  assign ifc.tready = rdy_c;
  assign ifg.tready = rdy_g;

  impulse_sweep_ctrl #(.WIDTH(16), .FFT_LEN(64), .DEC_FAC(48), .PULSE_VAL(1), .GAP_EN(0)) dut_c (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .phase_lo(phase_lo),
    .phase_hi(phase_hi), .frames(frames), .busy(busy_c), .done(done_c),
    .cur_phase(cur_phase_c), .m_axis(ifc)
  );

  impulse_sweep_ctrl #(.WIDTH(16), .FFT_LEN(64), .DEC_FAC(48), .PULSE_VAL(1), .GAP_EN(1)) dut_g (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .phase_lo(phase_lo),
    .phase_hi(phase_hi), .frames(frames), .busy(busy_g), .done(done_g),
    .cur_phase(cur_phase_g), .m_axis(ifg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int bound);
    int c;
    c = 0;
    while ((busy_c || busy_g || done_c || done_g) && c < bound) begin
      @(negedge clk);
      c++;
    end
    chk("idle", {30'd0, busy_c, busy_g}, 32'd0);
  endtask

  // Starts a sweep and follows the selected instance to its done pulse.
  task automatic run_stream(input string tag, input bit sel, input int lo, input int hi,
                            input int frm, input bit rnd, input int max_cyc,
                            output int gap_cyc, output int gap_runs, output int gap_at,
                            output int imp_cnt);
    int fe, total, nb, done_cnt, done_cyc, last_hs, ph_exp;
    bit v, r, dn, bz, pv, pr, prev_inv;
    logic [15:0] d, pd, exp_d;
    logic [5:0]  ph;
    fe = (frm == 0) ? 1 : frm;
    total = (hi >= lo) ? (hi - lo + 1) * fe * 64 : 0;
    nb = 0; done_cnt = 0; done_cyc = -1; last_hs = -1;
    pv = 1'b0; pr = 1'b1; pd = 16'd0; prev_inv = 1'b0; bz = 1'b0;
    gap_cyc = 0; gap_runs = 0; gap_at = -1; imp_cnt = 0;
    phase_lo = 6'(lo); phase_hi = 6'(hi); frames = 16'(frm);
    start = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      v  = sel ? ifg.tvalid : ifc.tvalid;
      d  = sel ? ifg.tdata : ifc.tdata;
      dn = sel ? done_g : done_c;
      bz = sel ? busy_g : busy_c;
      ph = sel ? cur_phase_g : cur_phase_c;
      if (dn) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (pv && !pr) begin
        chk({tag, "_stall_valid"}, {31'd0, v}, 32'd1);
        chk({tag, "_stall_data"}, {16'd0, d}, {16'd0, pd});
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sel) rdy_g = r; else rdy_c = r;
      if (nb > 0 && nb < total && !v && done_cnt == 0) begin
        gap_cyc++;
        if (!prev_inv) begin
          gap_runs++;
          if (gap_at < 0) gap_at = nb;
        end
      end
      prev_inv = !v;
      if (v && r) begin
        ph_exp = lo + (nb / 64) / fe;
        exp_d = ((nb % 64) == ph_exp) ? 16'd1 : 16'd0;
        chk({tag, "_data"}, {16'd0, d}, {16'd0, exp_d});
        chk({tag, "_phase"}, {26'd0, ph}, 32'(ph_exp));
        if (nb == 0) chk({tag, "_busy_run"}, {31'd0, bz}, 32'd1);
        if (d != 16'd0) imp_cnt++;
        nb++;
        last_hs = c;
      end
      pv = v; pr = r; pd = d;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    rdy_c = 1'b1; rdy_g = 1'b1;
    chk({tag, "_beats"}, 32'(nb), 32'(total));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_time"}, 32'(done_cyc), 32'(last_hs + 1));
    chk({tag, "_busy_end"}, {31'd0, bz}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    phase_lo = 6'd0; phase_hi = 6'd0; frames = 16'd0;
    rdy_c = 1'b1; rdy_g = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", {30'd0, ifc.tvalid, ifg.tvalid}, 32'd0);
    chk("rst_tdata", {ifc.tdata, ifg.tdata}, 32'd0);
    chk("rst_busy_done", {28'd0, busy_c, busy_g, done_c, done_g}, 32'd0);
    chk("rst_phase", {20'd0, cur_phase_c, cur_phase_g}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Continuous stream: impulses at beats 3 and 67.
    run_stream("cont", 1'b0, 3, 3, 2, 1'b0, 300, gcyc, gruns, gat, imp);
    chk("cont_gaps", 32'(gcyc), 32'd0);
    chk("cont_imp", 32'(imp), 32'd2);
    wait_idle(200);

    // Gapped stream: 48 beats, 16 idle cycles, 16 beats with the impulse at index 49.
    run_stream("gap", 1'b1, 49, 49, 1, 1'b0, 300, gcyc, gruns, gat, imp);
    chk("gap_cycles", 32'(gcyc), 32'd16);
    chk("gap_runs", 32'(gruns), 32'd1);
    chk("gap_at", 32'(gat), 32'd48);
    chk("gap_imp", 32'(imp), 32'd1);
    wait_idle(200);

    // Full phase sweep on the continuous instance.
    run_stream("sweep", 1'b0, 0, 63, 1, 1'b0, 4300, gcyc, gruns, gat, imp);
    chk("sweep_imp", 32'(imp), 32'd64);
    wait_idle(3000);

    // Random backpressure with gaps; the last gap coincides with the end of the sweep.
    run_stream("stall", 1'b1, 5, 5, 3, 1'b1, 3000, gcyc, gruns, gat, imp);
    chk("stall_imp", 32'(imp), 32'd3);
    chk("stall_gaps", 32'(gcyc), 32'd48);
    wait_idle(1500);

    // Abort at beat 30, with an ignored start mid-sweep.
    beats = 0;
    phase_lo = 6'd7; phase_hi = 6'd7; frames = 16'd1;
    start = 1'b1;
    for (int c = 0; c < 100 && beats < 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      phase_lo = 6'd7;
      if (c == 10) begin
        phase_lo = 6'd20;
        start = 1'b1;
      end
      if (ifc.tvalid) begin
        chk("abort_pre_data", {16'd0, ifc.tdata}, (beats == 7) ? 32'd1 : 32'd0);
        beats++;
      end
    end
    chk("abort_beats", 32'(beats), 32'd30);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_tvalid", {30'd0, ifc.tvalid, ifg.tvalid}, 32'd0);
    chk("abort_busy_done", {28'd0, busy_c, busy_g, done_c, done_g}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_done", {30'd0, done_c, done_g}, 32'd0);
    end
    run_stream("restart", 1'b0, 7, 7, 0, 1'b0, 200, gcyc, gruns, gat, imp);
    chk("restart_imp", 32'(imp), 32'd1);
    wait_idle(200);

    // Empty range: done one cycle after start, no beats.
    run_stream("empty", 1'b0, 10, 4, 1, 1'b0, 20, gcyc, gruns, gat, imp);
    wait_idle(20);

    // Asynchronous reset mid-run while the impulse is on the bus.
    phase_lo = 6'd2; phase_hi = 6'd2; frames = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_pre", {16'd0, ifc.tdata}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_tvalid", {30'd0, ifc.tvalid, ifg.tvalid}, 32'd0);
    chk("rst_mid_tdata", {ifc.tdata, ifg.tdata}, 32'd0);
    chk("rst_mid_busy", {30'd0, busy_c, busy_g}, 32'd0);
    chk("rst_mid_phase", {20'd0, cur_phase_c, cur_phase_g}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_mid_no_done", {28'd0, done_c, done_g, busy_c, busy_g}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
